hub75_scan_ctrl: RTL and testbench
==================================

Name: hub75_scan_ctrl

Overview:
- Frame-buffer-driven HUB75 scan controller for a 64x64, 1/32-scan LED panel. It replaces the free-running counter pattern with real image data.
- Reads pixel pairs (upper and lower half rows) from an external synchronous RAM, one bit plane at a time.
- Shifts each plane into the panel, latches it, then lights it for a binary-weighted time (BCM) to give BITS-bit colour per channel.
- Sits between the frame buffer and the panel connector pins.

Parameters:
- COLS, 64, columns per row; power of two.
- ADDR_W, 5, panel row-address width; ROWS_HALF = 2**ADDR_W.
- BITS, 4, bit planes per colour channel.
- BASE_TIME, 8, OE-low cycles for plane 0; plane p lights for BASE_TIME<<p cycles.
- COL_W, 6, log2(COLS).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  scan enable; sampled only in IDLE.
- fb_addr  out  ADDR_W+COL_W  read address, {row, col}.
- fb_data  in  6*BITS  read data, {b1,g1,r1,b0,g0,r0}, each BITS wide. Valid exactly 1 cycle after fb_addr.
- r0, g0, b0  out  1  upper-half colour bits.
- r1, g1, b1  out  1  lower-half colour bits.
- addr  out  ADDR_W  panel row address.
- clk_out  out  1  panel shift clock.
- latch  out  1  panel latch, active high.
- oe  out  1  panel output enable, active low (1 = blanked).
- frame_done  out  1  one-cycle pulse after the last plane of row ROWS_HALF-1 finishes display.

Behaviour:
- Reset (rst_n=0 at a clk edge) takes effect on the next edge:
  - state=IDLE; row=0, plane=0, col=0.
  - oe=1; latch=0, clk_out=0, addr=0.
  - r0..b1=0; fb_addr=0; frame_done=0.
  - Reset mid-operation aborts immediately; no partial latch is issued.
- All outputs are registered.
- States: IDLE -> FETCH -> SHIFT -> BLANK -> LATCH -> DISPLAY -> (FETCH | IDLE).
- IDLE:
  - oe=1.
  - If en=1, go to FETCH with the current row and plane.
  - If en=0, stay in IDLE.
- FETCH (1 cycle): fb_addr={row,0}; oe=1.
- SHIFT (2*COLS cycles), two cycles per column c:
  - Phase 0: clk_out=0 and colour outputs = bit `plane` of each fb_data field for column c, i.e. r0=fb_data[plane], g0=fb_data[BITS+plane], b0=fb_data[2*BITS+plane], r1=fb_data[3*BITS+plane], g1=fb_data[4*BITS+plane], b1=fb_data[5*BITS+plane].
  - Phase 1: clk_out=1 with colour outputs held. fb_addr advances to {row,c+1} in this phase so data arrives for the next phase 0.
  - Exactly COLS rising edges of clk_out per SHIFT.
  - Colour outputs never change while clk_out=1.
  - oe=1 throughout SHIFT.
- BLANK (1 cycle): clk_out=0, oe=1, addr<=row.
- LATCH (1 cycle): latch=1, oe=1. latch is 0 in every other state.
- DISPLAY (BASE_TIME<<plane cycles): oe=0; addr, latch and clk_out stable. oe=0 occurs in no other state.
- After DISPLAY:
  - If plane<BITS-1: plane+1, go to FETCH.
  - Else plane=0, then row+1.
  - If row was ROWS_HALF-1: row wraps to 0 and frame_done pulses for 1 cycle, coinciding with the first cycle of the next FETCH/IDLE.
  - Next state is FETCH if en=1, else IDLE.
- en is ignored outside IDLE and the DISPLAY exit; a deassertion mid-sequence completes the current plane.
- Cycle count per (row, plane): 1 + 2*COLS + 1 + 1 + (BASE_TIME<<plane).
- Defaults: 131 + {8,16,32,64} cycles, i.e. 644 cycles per row and 20608 cycles per frame.
- Counter wrap: col wraps COLS-1 -> 0 only at SHIFT exit. Width rules: plane is log2(BITS) wide, and the display counter is wide enough for BASE_TIME<<(BITS-1).

Test Plan:
- Reset with en=1, then release → first fb_addr=0 on the FETCH cycle; oe=1 until the first DISPLAY at cycle 132 after leaving IDLE; then oe=0 for exactly 8 cycles.
- RAM model returning fb_data = col replicated in every field (BITS=4), plane 0 → r0..b1 equal col[0] at each clk_out rising edge; 64 rising edges; then one latch pulse with addr=0 and oe=1.
- Full frame, en held high → plane lengths 8,16,32,64; addr steps 0..31; frame_done pulses once every 20608 cycles; oe=0 never coincides with latch=1 or clk_out toggling.
- en dropped during SHIFT of row 3, plane 1 → plane 1 completes its DISPLAY (16 cycles); controller enters IDLE with oe=1; re-raising en resumes at row 3, plane 2.
- rst_n pulsed low mid-SHIFT → next cycle all outputs hold reset values (oe=1, latch=0, addr=0); no latch pulse is issued.
- Per-pixel checker: pattern fb_data={row,col} hash, compare the reconstructed 64x64x4-bit image from the shifted bits against the model after one frame → zero mismatches.

Source files
------------

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller for a 64x64, 1/32-scan panel driven from a frame buffer.
// Each (row, plane) pass fetches one row pair from a synchronous RAM, shifts the
// selected bit plane into the panel, latches it, and lights it for a
// binary-weighted time so the panel shows BITS-bit colour per channel.
//
// The RAM address always runs one column ahead of the column on the panel
// pins. The colour registers can then load from fb_data on the same edge
// where clk_out falls. Colour therefore changes only while clk_out is low and
// stays put across the rising edge.
module hub75_scan_ctrl #(
  parameter int COLS      = 64,
  parameter int ADDR_W    = 5,
  parameter int BITS      = 4,
  parameter int BASE_TIME = 8,
  parameter int COL_W     = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic [ADDR_W+COL_W-1:0] fb_addr,
  input  logic [6*BITS-1:0]       fb_data,
  output logic                    r0,
  output logic                    g0,
  output logic                    b0,
  output logic                    r1,
  output logic                    g1,
  output logic                    b1,
  output logic [ADDR_W-1:0]       addr,
  output logic                    clk_out,
  output logic                    latch,
  output logic                    oe,
  output logic                    frame_done
);

  localparam int PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int DISP_W  = $clog2((BASE_TIME << (BITS - 1)) + 1);

  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BITS - 1);
  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
  localparam logic [DISP_W-1:0]  BASE_T     = DISP_W'(BASE_TIME);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   row_reg;
  logic [PLANE_W-1:0]  plane_reg;
  logic [COL_W-1:0]    col_reg;
  logic                phase_reg;
  logic [DISP_W-1:0]   disp_cnt_reg;

  // One BITS-wide field per colour channel, ordered {b1,g1,r1,b0,g0,r0}.
  logic [BITS-1:0]     field [6];
  logic [5:0]          plane_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_field
      assign field[gi]      = fb_data[gi*BITS +: BITS];
      assign plane_bits[gi] = field[gi][plane_reg];
    end
  endgenerate

  // Row/plane that the pass after the current one will use.
  logic               last_plane;
  logic               last_row;
  logic [PLANE_W-1:0] plane_next;
  logic [ADDR_W-1:0]  row_next;

  assign last_plane = (plane_reg == LAST_PLANE);
  assign last_row   = (row_reg == '1);
  assign plane_next = last_plane ? '0 : plane_reg + PLANE_W'(1);
  assign row_next   = last_plane ? row_reg + ADDR_W'(1) : row_reg;

  // Scan sequencer: every output is loaded on the edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      row_reg      <= '0;
      plane_reg    <= '0;
      col_reg      <= '0;
      phase_reg    <= 1'b0;
      disp_cnt_reg <= '0;
      fb_addr      <= '0;
      {b1, g1, r1, b0, g0, r0} <= 6'b0;
      addr         <= '0;
      clk_out      <= 1'b0;
      latch        <= 1'b0;
      oe           <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          oe <= 1'b1;
          if (en) state_reg <= ST_FETCH;
        end
        // fb_addr already holds {row,0}, so column 0 is on fb_data now.
        ST_FETCH: begin
          {b1, g1, r1, b0, g0, r0} <= plane_bits;
          clk_out   <= 1'b0;
          col_reg   <= '0;
          phase_reg <= 1'b0;
          fb_addr   <= {row_reg, COL_W'(1)};
          state_reg <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!phase_reg) begin
            phase_reg <= 1'b1;
            clk_out   <= 1'b1;
          end else begin
            phase_reg <= 1'b0;
            clk_out   <= 1'b0;
            if (col_reg == LAST_COL) begin
              col_reg   <= '0;
              addr      <= row_reg;
              state_reg <= ST_BLANK;
            end else begin
              col_reg   <= col_reg + COL_W'(1);
              fb_addr   <= {row_reg, col_reg + COL_W'(2)};
              {b1, g1, r1, b0, g0, r0} <= plane_bits;
            end
          end
        end
        ST_BLANK: begin
          latch     <= 1'b1;
          state_reg <= ST_LATCH;
        end
        // Point the RAM at column 0 of the next pass while the panel is lit.
        ST_LATCH: begin
          latch        <= 1'b0;
          oe           <= 1'b0;
          disp_cnt_reg <= (BASE_T << plane_reg) - DISP_W'(1);
          fb_addr      <= {row_next, COL_W'(0)};
          state_reg    <= ST_DISPLAY;
        end
        ST_DISPLAY: begin
          if (disp_cnt_reg == '0) begin
            oe        <= 1'b1;
            plane_reg <= plane_next;
            row_reg   <= row_next;
            if (last_plane && last_row) frame_done <= 1'b1;
            state_reg <= en ? ST_FETCH : ST_IDLE;
          end else begin
            disp_cnt_reg <= disp_cnt_reg - DISP_W'(1);
          end
        end
        default: begin
          oe        <= 1'b1;
          latch     <= 1'b0;
          clk_out   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl.
// A synchronous RAM model holds a seeded hash image.
// A negedge monitor rebuilds the displayed image from the panel pins.
// The monitor also logs latch, display and frame events.
// The main sequence checks those logs against lengths and addresses worked out from the scan rules.
module tb_hub75_scan_ctrl;
  localparam int COLS      = 64;
  localparam int ADDR_W    = 5;
  localparam int BITS      = 4;
  localparam int BASE_TIME = 8;
  localparam int COL_W     = 6;
  localparam int ROWS      = 1 << ADDR_W;
  localparam int SEG_OVH   = 1 + 2*COLS + 1 + 1;
  localparam int FRAME     = ROWS * (BITS*SEG_OVH + BASE_TIME*((1 << BITS) - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [ADDR_W+COL_W-1:0] fb_addr;
  logic [6*BITS-1:0] fb_data = '0;
  logic r0, g0, b0, r1, g1, b1;
  logic [ADDR_W-1:0] addr;
  logic clk_out, latch, oe, frame_done;

  hub75_scan_ctrl #(
    .COLS(COLS), .ADDR_W(ADDR_W), .BITS(BITS), .BASE_TIME(BASE_TIME), .COL_W(COL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fb_addr(fb_addr), .fb_data(fb_data),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .addr(addr), .clk_out(clk_out), .latch(latch), .oe(oe), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] seed = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Image content: seeded hash of (row, col), fields {b1,g1,r1,b0,g0,r0}.
  function automatic logic [6*BITS-1:0] pix(input int r, input int c);
    logic [31:0] v;
    v = seed ^ (32'(r) * 32'h9E3779B1) ^ (32'(c) * 32'h85EBCA77);
    v = v ^ (v >> 13);
    v = v * 32'hC2B2AE35;
    v = v ^ (v >> 16);
    return v[6*BITS-1:0];
  endfunction

  function automatic int plane_of(input int len);
    for (int p = 0; p < BITS; p++) if ((BASE_TIME << p) == len) return p;
    return -1;
  endfunction

  // Synchronous frame-buffer RAM, one cycle read latency.
  always @(posedge clk) fb_data <= pix(int'(fb_addr[COL_W +: ADDR_W]), int'(fb_addr[COL_W-1:0]));

  // Panel-side monitor.
  wire [5:0] col_vec = {b1, g1, r1, b0, g0, r0};
  logic [5:0] cur_bits  [COLS];
  logic [5:0] pend_bits [COLS];
  logic [5:0] img [BITS][ROWS][COLS];
  logic [ADDR_W-1:0] pend_addr = '0;
  logic prev_clk_out = 1'b0;
  logic prev_oe = 1'b1;
  logic [5:0] prev_col = 6'b0;
  int shift_idx = 0;
  int run_len = 0;
  int rise_total = 0;
  int viol = 0;
  int latch_q[$];
  int rise_q[$];
  int disp_q[$];
  int fd_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      shift_idx    <= 0;
      run_len      <= 0;
      prev_clk_out <= 1'b0;
      prev_oe      <= 1'b1;
      prev_col     <= col_vec;
    end else begin
      prev_clk_out <= clk_out;
      prev_oe      <= oe;
      prev_col     <= col_vec;
      if (clk_out && !prev_clk_out) begin
        if (shift_idx < COLS) cur_bits[shift_idx] <= col_vec;
        shift_idx  <= shift_idx + 1;
        rise_total <= rise_total + 1;
        if (col_vec !== prev_col) viol <= viol + 1;
      end
      if (!oe && (latch || (clk_out !== prev_clk_out))) viol <= viol + 1;
      if (latch) begin
        latch_q.push_back(int'(addr));
        rise_q.push_back(shift_idx);
        pend_bits <= cur_bits;
        pend_addr <= addr;
        shift_idx <= 0;
      end
      if (!oe) begin
        run_len <= run_len + 1;
      end else if (!prev_oe) begin
        disp_q.push_back(run_len);
        if (plane_of(run_len) < 0) viol <= viol + 1;
        else for (int c = 0; c < COLS; c++) img[plane_of(run_len)][pend_addr][c] <= pend_bits[c];
        run_len <= 0;
      end
      if (frame_done) fd_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"}, 32'(oe), 1);
    check({tag, "_latch"}, 32'(latch), 0);
    check({tag, "_clk_out"}, 32'(clk_out), 0);
    check({tag, "_addr"}, 32'(addr), 0);
    check({tag, "_fb_addr"}, 32'(fb_addr), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_colour"}, 32'(col_vec), 0);
  endtask

  initial begin
    int n, fetch_start, bad_len, bad_addr, bad_rise, mism, lbase, dbase, rbase, k, lsz, rsz;
    logic [6*BITS-1:0] exp_px;

    seed = $urandom;
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Leave reset with en high: first FETCH, then 131 blanked cycles.
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fetch_start = cyc;
    check("fetch_fb_addr", 32'(fb_addr), 0);
    check("fetch_oe", 32'(oe), 1);
    n = 0;
    while (oe === 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_display_cycle", n, SEG_OVH);

    // Two full frames with en held high.
    for (int i = 0; i < 3*FRAME && fd_q.size() < 2; i++) @(posedge clk);
    #1;
    check("frame_done_seen", fd_q.size(), 2);
    if (fd_q.size() >= 2) begin
      check("first_frame_done_cycle", fd_q[0] - fetch_start, FRAME);
      check("frame_period", fd_q[1] - fd_q[0], FRAME);
    end
    check("first_display_len", (disp_q.size() > 0) ? disp_q[0] : -1, BASE_TIME);
    check("first_latch_addr", (latch_q.size() > 0) ? latch_q[0] : -1, 0);
    check("first_shift_edges", (rise_q.size() > 0) ? rise_q[0] : -1, COLS);
    bad_len = 0;
    bad_addr = 0;
    bad_rise = 0;
    for (int i = 0; i < ROWS*BITS; i++) begin
      if (i >= disp_q.size() || disp_q[i] != (BASE_TIME << (i % BITS))) bad_len++;
      if (i >= latch_q.size() || latch_q[i] != i / BITS) bad_addr++;
      if (i >= rise_q.size() || rise_q[i] != COLS) bad_rise++;
    end
    check("plane_lengths_bad", bad_len, 0);
    check("latch_addr_bad", bad_addr, 0);
    check("shift_edges_bad", bad_rise, 0);
    mism = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp_px = pix(r, c);
        for (int p = 0; p < BITS; p++)
          for (int f = 0; f < 6; f++)
            if (img[p][r][c][f] !== exp_px[f*BITS + p]) mism++;
      end
    check("image_mismatches", mism, 0);
    check("timing_violations", viol, 0);

    // en dropped during SHIFT of row 3, plane 1.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lbase = latch_q.size();
    dbase = disp_q.size();
    for (int i = 0; i < 5000 && latch_q.size() - lbase < 3*BITS + 1; i++) @(posedge clk);
    #1;
    check("drop_reach_row3", latch_q.size() - lbase, 3*BITS + 1);
    rbase = rise_total;
    k = $urandom_range(1, 60);
    for (int i = 0; i < 300 && rise_total - rbase < k; i++) @(posedge clk);
    #1;
    check("drop_in_shift", rise_total - rbase, k);
    en = 1'b0;
    for (int i = 0; i < 400 && disp_q.size() - dbase < 3*BITS + 2; i++) @(posedge clk);
    #1;
    check("drop_segments", disp_q.size() - dbase, 3*BITS + 2);
    if (disp_q.size() - dbase >= 3*BITS + 2) begin
      check("drop_plane1_len", disp_q[dbase + 3*BITS + 1], 2*BASE_TIME);
      check("drop_latch_addr", latch_q[lbase + 3*BITS + 1], 3);
    end
    lsz = latch_q.size();
    rsz = rise_total;
    repeat (50) @(posedge clk);
    #1;
    check("idle_oe", 32'(oe), 1);
    check("idle_no_latch", latch_q.size(), lsz);
    check("idle_no_shift", rise_total, rsz);
    en = 1'b1;
    for (int i = 0; i < 600 && disp_q.size() - dbase < 3*BITS + 3; i++) @(posedge clk);
    #1;
    check("resume_segments", disp_q.size() - dbase, 3*BITS + 3);
    if (disp_q.size() - dbase >= 3*BITS + 3) begin
      check("resume_latch_addr", latch_q[lbase + 3*BITS + 2], 3);
      check("resume_plane2_len", disp_q[dbase + 3*BITS + 2], 4*BASE_TIME);
    end

    // Reset pulsed in the middle of a SHIFT.
    rbase = rise_total;
    k = $urandom_range(2, 60);
    for (int i = 0; i < 300 && rise_total - rbase < k; i++) @(posedge clk);
    #1;
    check("mid_shift_reached", rise_total - rbase, k);
    lsz = latch_q.size();
    rst_n = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    rsz = rise_total;
    repeat (300) @(posedge clk);
    #1;
    check("mid_reset_no_latch", latch_q.size(), lsz);
    check("mid_reset_no_shift", rise_total, rsz);
    check("mid_reset_oe", 32'(oe), 1);
    check("final_timing_violations", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
